// File: rtl/mac_frame_checker.sv
// Receive-side MAC frame checker: strips preamble, captures header fields, counts
// frame bytes, checks CRC-32/length/size and emits one status record per frame.
module mac_frame_checker #(
  parameter int PAYLOAD_MAX_SIZE = 1500
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_keep,
  input  logic        i_last,
  input  logic [47:0] i_local_address,
  output logic        o_done,
  output logic [47:0] o_dest_address,
  output logic [47:0] o_src_address,
  output logic [15:0] o_eth_type,
  output logic [15:0] o_frame_bytes,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic        o_runt,
  output logic        o_giant,
  output logic        o_preamble_err,
  output logic        o_addr_match
);

  localparam logic [63:0] PREAMBLE    = 64'hD555555555555555;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [16:0] GIANT_LIMIT = 17'(PAYLOAD_MAX_SIZE + 18);

  typedef enum logic [2:0] {IDLE, HDR1, HDR2, BODY, DROP} state_e;

  function automatic logic [3:0] lane_count(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, keep[i]};
    return n;
  endfunction

  // Reflected CRC-32, one byte per enabled lane, lane 0 first.
  function automatic logic [31:0] crc_word(input logic [31:0] crc_in,
                                           input logic [63:0] data,
                                           input logic [7:0]  keep);
    logic [31:0] c;
    c = crc_in;
    for (int lane = 0; lane < 8; lane++) begin
      if (keep[lane]) begin
        c = c ^ {24'h000000, data[lane*8 +: 8]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] bytes_q, bytes_d;
  logic [47:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] eth_q, eth_d;
  logic        match_q, match_d;

  logic        done_q, done_d;
  logic [47:0] rpt_dest_q, rpt_dest_d;
  logic [47:0] rpt_src_q, rpt_src_d;
  logic [15:0] rpt_eth_q, rpt_eth_d;
  logic [15:0] rpt_bytes_q, rpt_bytes_d;
  logic        rpt_crc_err_q, rpt_crc_err_d;
  logic        rpt_len_err_q, rpt_len_err_d;
  logic        rpt_runt_q, rpt_runt_d;
  logic        rpt_giant_q, rpt_giant_d;
  logic        rpt_pre_err_q, rpt_pre_err_d;
  logic        rpt_match_q, rpt_match_d;

  logic        report, hdr_short, pre_bad;
  logic [16:0] bytes_sum;
  logic [15:0] bytes_acc;
  logic [31:0] crc_acc;
  logic [15:0] field_len, min_len;
  logic        runt_c, giant_c, len_c, crc_err_c;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    bytes_d   = bytes_q;
    dest_d    = dest_q;
    src_d     = src_q;
    eth_d     = eth_q;
    match_d   = match_q;
    report    = 1'b0;
    hdr_short = 1'b0;
    pre_bad   = 1'b0;
    bytes_sum = {1'b0, bytes_q} + {13'h0000, lane_count(i_keep)};
    bytes_acc = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
    crc_acc   = crc_word(crc_q, i_data, i_keep);

    if (i_valid) begin
      case (state_q)
        IDLE: begin
          crc_d   = '1;
          bytes_d = '0;
          dest_d  = '0;
          src_d   = '0;
          eth_d   = '0;
          match_d = 1'b0;
          if (i_data == PREAMBLE && i_keep == 8'hFF) begin
            if (i_last) begin
              report    = 1'b1;
              hdr_short = 1'b1;
            end else begin
              state_d = HDR1;
            end
          end else begin
            pre_bad = 1'b1;
            if (i_last) report = 1'b1;
            else        state_d = DROP;
          end
        end
        HDR1: begin
          crc_d   = crc_acc;
          bytes_d = bytes_acc;
          dest_d  = i_data[47:0];
          src_d   = {32'h0, i_data[63:48]};
          match_d = (i_data[47:0] == i_local_address) || (i_data[47:0] == 48'hFFFF_FFFF_FFFF);
          if (i_last) begin
            report    = 1'b1;
            hdr_short = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = HDR2;
          end
        end
        HDR2: begin
          crc_d   = crc_acc;
          bytes_d = bytes_acc;
          src_d   = {i_data[31:0], src_q[15:0]};
          eth_d   = i_data[47:32];
          if (i_last) begin
            report    = 1'b1;
            hdr_short = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          crc_d   = crc_acc;
          bytes_d = bytes_acc;
          if (i_last) begin
            report  = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          bytes_d = bytes_acc;
          if (i_last) begin
            report  = 1'b1;
            pre_bad = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame checks use the values as they stand after absorbing the current word.
    runt_c    = (bytes_d < 16'd64) || hdr_short;
    giant_c   = {1'b0, bytes_d} > GIANT_LIMIT;
    field_len = bytes_d - 16'd18;
    min_len   = (eth_d < 16'd46) ? 16'd46 : eth_d;
    len_c     = 1'b0;
    if (!runt_c) begin
      if (eth_d <= 16'd1500)      len_c = (field_len != min_len);
      else if (eth_d <= 16'd1535) len_c = 1'b1;
    end
    crc_err_c = pre_bad ? 1'b0 : (hdr_short || (crc_d != CRC_RESIDUE));

    done_d        = report;
    rpt_dest_d    = rpt_dest_q;
    rpt_src_d     = rpt_src_q;
    rpt_eth_d     = rpt_eth_q;
    rpt_bytes_d   = rpt_bytes_q;
    rpt_crc_err_d = rpt_crc_err_q;
    rpt_len_err_d = rpt_len_err_q;
    rpt_runt_d    = rpt_runt_q;
    rpt_giant_d   = rpt_giant_q;
    rpt_pre_err_d = rpt_pre_err_q;
    rpt_match_d   = rpt_match_q;
    if (report) begin
      rpt_dest_d    = dest_d;
      rpt_src_d     = src_d;
      rpt_eth_d     = eth_d;
      rpt_bytes_d   = bytes_d;
      rpt_crc_err_d = crc_err_c;
      rpt_len_err_d = len_c;
      rpt_runt_d    = runt_c;
      rpt_giant_d   = giant_c;
      rpt_pre_err_d = pre_bad;
      rpt_match_d   = match_d;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      crc_q         <= '1;
      bytes_q       <= '0;
      dest_q        <= '0;
      src_q         <= '0;
      eth_q         <= '0;
      match_q       <= 1'b0;
      done_q        <= 1'b0;
      rpt_dest_q    <= '0;
      rpt_src_q     <= '0;
      rpt_eth_q     <= '0;
      rpt_bytes_q   <= '0;
      rpt_crc_err_q <= 1'b0;
      rpt_len_err_q <= 1'b0;
      rpt_runt_q    <= 1'b0;
      rpt_giant_q   <= 1'b0;
      rpt_pre_err_q <= 1'b0;
      rpt_match_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      bytes_q       <= bytes_d;
      dest_q        <= dest_d;
      src_q         <= src_d;
      eth_q         <= eth_d;
      match_q       <= match_d;
      done_q        <= done_d;
      rpt_dest_q    <= rpt_dest_d;
      rpt_src_q     <= rpt_src_d;
      rpt_eth_q     <= rpt_eth_d;
      rpt_bytes_q   <= rpt_bytes_d;
      rpt_crc_err_q <= rpt_crc_err_d;
      rpt_len_err_q <= rpt_len_err_d;
      rpt_runt_q    <= rpt_runt_d;
      rpt_giant_q   <= rpt_giant_d;
      rpt_pre_err_q <= rpt_pre_err_d;
      rpt_match_q   <= rpt_match_d;
    end
  end

  assign o_done         = done_q;
  assign o_dest_address = rpt_dest_q;
  assign o_src_address  = rpt_src_q;
  assign o_eth_type     = rpt_eth_q;
  assign o_frame_bytes  = rpt_bytes_q;
  assign o_crc_err      = rpt_crc_err_q;
  assign o_len_err      = rpt_len_err_q;
  assign o_runt         = rpt_runt_q;
  assign o_giant        = rpt_giant_q;
  assign o_preamble_err = rpt_pre_err_q;
  assign o_addr_match   = rpt_match_q;

endmodule
